// File: rtl/aes_spi_frontend.sv
// SPI slave front end for an AES core: oversamples sck in the clk domain, shifts in
// {plaintext, key}, pulses start, captures the core result and shifts it out on sdo.
module aes_spi_frontend #(
    parameter int KEY_BITS   = 128,
    parameter int BLOCK_BITS = 128,
    parameter int KEY_REUSE  = 1,
    parameter int CNT_W      = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    output logic                  sdo,
    output logic                  done,
    output logic                  frame_err,
    output logic [KEY_BITS-1:0]   key,
    output logic [BLOCK_BITS-1:0] plaintext,
    output logic                  start,
    input  logic                  core_done,
    input  logic [BLOCK_BITS-1:0] cyphertext
);
    localparam int FRAME_BITS = KEY_BITS + BLOCK_BITS;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_BITS);
    localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(BLOCK_BITS - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {IDLE, SHIFT_IN, START, WAIT, HOLD, SHIFT_OUT} state_e;

    state_e                  state_q;
    logic [2:0]              sck_q;
    logic [1:0]              sdi_q;
    logic [2:0]              load_q;
    logic [CNT_W-1:0]        count_q;
    logic [FRAME_BITS-1:0]   in_sr_q;
    logic [BLOCK_BITS-1:0]   out_sr_q;
    logic [KEY_BITS-1:0]     key_q;
    logic [BLOCK_BITS-1:0]   pt_q;
    logic                    sdo_q, done_q, err_q, start_q;

    logic sck_rise, sck_fall, load_rise, load_fall;

    // sdi is taken from the same stage as sck so data and edge stay aligned
    assign sck_rise  =  sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] &  sck_q[2];
    assign load_rise =  load_q[1] & ~load_q[2];
    assign load_fall = ~load_q[1] &  load_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sck_q    <= '0;
            sdi_q    <= '0;
            load_q   <= '0;
            count_q  <= '0;
            in_sr_q  <= '0;
            out_sr_q <= '0;
            key_q    <= '0;
            pt_q     <= '0;
            sdo_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            sck_q   <= {sck_q[1:0], sck};
            sdi_q   <= {sdi_q[0], sdi};
            load_q  <= {load_q[1:0], load};
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_rise) begin
                        state_q <= SHIFT_IN;
                        count_q <= '0;
                    end
                end
                SHIFT_IN: begin
                    if (sck_rise) begin
                        in_sr_q <= {in_sr_q[FRAME_BITS-2:0], sdi_q[1]};
                        if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
                    end
                    if (load_fall) begin
                        if (count_q == FRAME_CNT) begin
                            pt_q    <= in_sr_q[FRAME_BITS-1 -: BLOCK_BITS];
                            key_q   <= in_sr_q[KEY_BITS-1:0];
                            err_q   <= 1'b0;
                            start_q <= 1'b1;
                            state_q <= START;
                        end else if (KEY_REUSE != 0 && count_q == BLOCK_CNT) begin
                            pt_q    <= in_sr_q[BLOCK_BITS-1:0];
                            err_q   <= 1'b0;
                            start_q <= 1'b1;
                            state_q <= START;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        out_sr_q <= cyphertext;
                        sdo_q    <= cyphertext[BLOCK_BITS-1];
                        done_q   <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (sck_rise) begin
                        state_q <= SHIFT_OUT;
                        count_q <= '0;
                    end
                end
                SHIFT_OUT: begin
                    // the first rise was consumed in HOLD, so count trails the rise index by one
                    if (sck_rise) begin
                        if (count_q == LAST_OUT) begin
                            done_q  <= 1'b0;
                            sdo_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end else if (sck_fall) begin
                        out_sr_q <= out_sr_q << 1;
                        sdo_q    <= out_sr_q[BLOCK_BITS-2];
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load_rise && (state_q == WAIT || state_q == HOLD || state_q == SHIFT_OUT)) begin
                done_q  <= 1'b0;
                sdo_q   <= 1'b0;
                count_q <= '0;
                state_q <= SHIFT_IN;
            end
        end
    end

    assign sdo       = sdo_q;
    assign done      = done_q;
    assign frame_err = err_q;
    assign key       = key_q;
    assign plaintext = pt_q;
    assign start     = start_q;
endmodule

// File: tb/tb_aes_spi_frontend.sv
// Three front ends (128-bit key, 256-bit key, 128-bit key without reuse) share one SPI bus;
// a frame-level model predicts each one's start/key/plaintext and its read-back ciphertext.
module tb_aes_spi_frontend;
    localparam int HALF = 4;
    localparam logic [127:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PT1  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] CT1  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [255:0] KEY2 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] PT2  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CT2  = 128'h8EA2B7CA516745BFEAFC49904B496089;

    logic clk = 1'b0;
    logic reset_n, sck, sdi, load;
    logic         sdo_a [3];
    logic         done_a [3];
    logic         ferr_a [3];
    logic         start_a [3];
    logic [255:0] key_a [3];
    logic [127:0] pt_a [3];
    logic         cdone_a [3];
    logic [127:0] ct_a [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [383:0] exp_kp [3][$];
    logic [127:0] exp_ct [3][$];
    logic [255:0] m_key [3];
    logic [127:0] m_pt [3];
    logic         m_err [3];
    logic         m_acc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB = (g == 1) ? 256 : 128;
        localparam int RU = (g == 2) ? 0 : 1;
        logic [KB-1:0] k;
        aes_spi_frontend #(.KEY_BITS(KB), .BLOCK_BITS(128), .KEY_REUSE(RU), .CNT_W(9)) u_dut (
            .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
            .sdo(sdo_a[g]), .done(done_a[g]), .frame_err(ferr_a[g]),
            .key(k), .plaintext(pt_a[g]), .start(start_a[g]),
            .core_done(cdone_a[g]), .cyphertext(ct_a[g]));
        assign key_a[g] = 256'(k);
    end

    // Stand-in AES core: known answers for the reference vectors, a fixed mix otherwise
    function automatic logic [127:0] fake_ct(input logic [255:0] k, input logic [127:0] p);
        if (k == 256'(KEY1) && p == PT1) return CT1;
        if (k == KEY2 && p == PT2) return CT2;
        return {p[63:0], p[127:64]} ^ k[127:0] ^ k[255:128] ^ 128'h5A5A_0F0F_C3C3_9696_1234_5678_9ABC_DEF0;
    endfunction

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor + core model: pops expectations on start pulses and on each 128-bit read-back
    initial begin
        int           nb [3];
        int           cd [3];
        bit           pend [3];
        logic [127:0] acc [3];
        logic         sck_prev;
        logic [383:0] e;
        sck_prev = 1'b0;
        for (int d = 0; d < 3; d++) begin
            nb[d] = 0; cd[d] = 0; pend[d] = 0; acc[d] = '0; cdone_a[d] = 1'b0; ct_a[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                cdone_a[d] = 1'b0;
                if (!reset_n) begin
                    nb[d] = 0; pend[d] = 0;
                    continue;
                end
                if (pend[d]) begin
                    cd[d]--;
                    if (cd[d] == 0) begin
                        pend[d]    = 0;
                        ct_a[d]    = fake_ct(key_a[d], pt_a[d]);
                        cdone_a[d] = 1'b1;
                    end
                end
                if (start_a[d]) begin
                    if (exp_kp[d].size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_start[%0d]: actual start=1 required start=0", d);
                    end else begin
                        e = exp_kp[d].pop_front();
                        check($sformatf("start_key_pt[%0d]", d), {key_a[d], pt_a[d]}, e);
                    end
                    pend[d] = 1;
                    cd[d]   = $urandom_range(2, 6);
                end
                if (sck && !sck_prev) begin
                    if (done_a[d]) begin
                        acc[d] = {acc[d][126:0], sdo_a[d]};
                        nb[d]++;
                        if (nb[d] == 128) begin
                            nb[d] = 0;
                            if (exp_ct[d].size() == 0) begin
                                n_cmp++; n_err++;
                                $display("FAIL unexpected_readout[%0d]: actual %0h required none", d, acc[d]);
                            end else begin
                                check($sformatf("readout[%0d]", d), 384'(acc[d]), 384'(exp_ct[d].pop_front()));
                            end
                        end
                    end else begin
                        nb[d] = 0;
                    end
                end
            end
            sck_prev = sck;
        end
    end

    task automatic half();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic sck_bit(input logic b);
        sdi = b;
        half();
        sck = 1'b1;
        half();
        sck = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_key[d] = '0; m_pt[d] = '0; m_err[d] = 1'b0; m_acc[d] = 1'b0;
        end
    endtask

    task automatic model_frame(input int d, input logic [383:0] bits, input int n);
        int KB;
        KB = (d == 1) ? 256 : 128;
        m_acc[d] = 1'b0;
        if (n == KB + 128) begin
            m_pt[d]  = 128'(bits >> KB);
            m_key[d] = (KB == 256) ? bits[255:0] : {128'b0, bits[127:0]};
            m_acc[d] = 1'b1;
        end else if (n == 128 && d != 2) begin
            m_pt[d]  = bits[127:0];
            m_acc[d] = 1'b1;
        end
        m_err[d] = !m_acc[d];
        if (m_acc[d]) exp_kp[d].push_back({m_key[d], m_pt[d]});
    endtask

    task automatic reset_mid_frame();
        reset_n = 1'b0; load = 1'b0; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_flags[%0d]", d), {sdo_a[d], done_a[d], ferr_a[d], start_a[d]}, 0);
            check($sformatf("reset_key_pt[%0d]", d), {key_a[d], pt_a[d]}, 0);
        end
        model_reset();
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // rst_at >= 0 pulls reset_n after that many bits instead of finishing the frame
    task automatic send_frame(input logic [383:0] bits, input int n, input int rst_at);
        load = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("done_after_load[%0d]", d), done_a[d], 0);
        for (int i = n - 1; i >= 0; i--) begin
            if (n - 1 - i == rst_at) begin
                reset_mid_frame();
                return;
            end
            sck_bit(bits[i]);
        end
        for (int d = 0; d < 3; d++) model_frame(d, bits, n);
        half();
        load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("frame_err[%0d]", d), ferr_a[d], m_err[d]);
    endtask

    function automatic bit all_done();
        for (int d = 0; d < 3; d++) if (m_acc[d] && !done_a[d]) return 1'b0;
        return 1'b1;
    endfunction

    // nbits < 128 leaves the result partially read so the next frame aborts it
    task automatic readback(input int nbits);
        int t;
        t = 0;
        while (t < 100 && !all_done()) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int d = 0; d < 3; d++) check($sformatf("done_ready[%0d]", d), done_a[d], m_acc[d]);
        if (nbits == 128)
            for (int d = 0; d < 3; d++) if (m_acc[d]) exp_ct[d].push_back(fake_ct(m_key[d], m_pt[d]));
        for (int i = 0; i < nbits; i++) sck_bit(1'($urandom));
        if (nbits == 128) begin
            repeat (6) @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) check($sformatf("done_sdo_low[%0d]", d), {done_a[d], sdo_a[d]}, 0);
        end
        for (int d = 0; d < 3; d++) m_acc[d] = 1'b0;
    endtask

    initial begin
        logic [383:0] f1, f2, f3, fr;
        int           len;
        f1 = 384'({PT1, KEY1});
        f2 = {PT2, KEY2};
        f3 = 384'(PT2);
        reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; load = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("por_flags[%0d]", d), {sdo_a[d], done_a[d], ferr_a[d], start_a[d]}, 0);
            check($sformatf("por_key_pt[%0d]", d), {key_a[d], pt_a[d]}, 0);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send_frame(f1, 256, -1); readback(128);   // 128-bit key vector
        send_frame(f2, 384, -1); readback(128);   // 256-bit key vector
        send_frame(f3, 128, -1); readback(128);   // key-reuse frame
        fr = 384'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        fr = fr & ((384'(1) << 200) - 1);
        send_frame(fr, 200, -1); readback(128);   // bad length everywhere
        send_frame(f1, 256, -1); readback(128);
        send_frame(f1, 256, 100);                 // reset mid-frame
        send_frame(f1, 256, -1); readback(128);
        send_frame(f1, 256, -1); readback(40);    // abort during shift-out
        send_frame(f2, 384, -1); readback(128);

        for (int it = 0; it < 5; it++) begin
            case ($urandom_range(0, 3))
                0: len = 128;
                1: len = 256;
                2: len = 384;
                default: len = $urandom_range(100, 300);
            endcase
            fr = 384'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            fr = fr & ((384'(1) << len) - 1);
            send_frame(fr, len, -1);
            readback(($urandom_range(0, 2) == 0) ? 40 : 128);
        end
        send_frame(f1, 256, -1); readback(128);

        repeat (10) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("kp_queue_empty[%0d]", d), exp_kp[d].size(), 0);
            check($sformatf("ct_queue_empty[%0d]", d), exp_ct[d].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
